trig_lut_scheduler: RTL and testbench
=====================================

Name: trig_lut_scheduler

Overview:
Shares one bank of six registered trig lookup tables (sin, cos, tan, cot, sec, cosec) among NUM_REQ requesters using round-robin arbitration. For each granted request it reduces an arbitrary unsigned angle in degrees to a quadrant and a 0..90 reference angle, and drives the one-hot LUT enable, quadrant and angle. It captures the 64-bit LUT result and returns it to the requester over a valid/ready handshake, tagged with the requester ID. It sits between the command front-end and the LUT bank, and is the only driver of the LUT inputs.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- ANGLE_W, 16: request angle width, in unsigned whole degrees.
- ID_W, 2: requester ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_func  in  NUM_REQ*3  per-requester function code: 0 sin, 1 cos, 2 tan, 3 cot, 4 sec, 5 cosec
- req_angle  in  NUM_REQ*ANGLE_W  per-requester angle
- lut_en  out  6  one-hot LUT enable, bit index = function code
- lut_quadrant  out  2  quadrant to the LUTs
- lut_angle  out  `DATA_WIDTH  reference angle 0..90
- lut_result  in  `DATA_WIDTH*2  OR of the LUT data_out buses
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer ready
- resp_data  out  `DATA_WIDTH*2  captured IEEE-754 double
- resp_id  out  ID_W  requester that owns resp_data
- busy  out  1  high in any state other than IDLE

Behaviour:
Reset values: state=IDLE, rr_ptr=0, req_ready=0, lut_en=0, lut_quadrant=0, lut_angle=0, resp_valid=0, resp_data=0, resp_id=0. Reset mid-operation aborts the transaction; no response is produced.

FSM states: IDLE, REDUCE, QUAD, ISSUE, CAPTURE, RESP.
- IDLE: if any req_valid is set, grant the first valid index at or after rr_ptr (wrap-around).
  - Pulse req_ready[grant] for 1 cycle.
  - Latch func, angle and ID.
  - Set rr_ptr = grant+1 mod NUM_REQ.
  - Go to REDUCE.
- REDUCE: while angle >= 360, subtract 360 (one subtraction per cycle). Otherwise go to QUAD. This takes k = floor(angle/360) cycles plus 1.
- QUAD: sets quadrant and reference angle a:
  - a<90: q=0, ref=a
  - 90<=a<180: q=1, ref=180-a
  - 180<=a<270: q=2, ref=a-180
  - else: q=3, ref=360-a
  - Boundary angles 90/180/270 resolve to q=1/2/3 with ref 90/0/90.
  - Drive lut_quadrant and lut_angle; both hold until RESP.
- ISSUE: lut_en = one-hot(func); go to CAPTURE.
- CAPTURE: lut_en stays asserted. Register resp_data <= lut_result at the end of the cycle, then deassert lut_en. Go to RESP.
- RESP: resp_valid=1. resp_data and resp_id are stable until resp_valid && resp_ready, then go to IDLE.
  - No new grant occurs before the handshake; the earliest next grant is the cycle after it.

Rules:
- Fixed latency: resp_valid is first high k+4 cycles after the accept edge.
- An invalid func code (6, 7) skips ISSUE/CAPTURE and returns resp_data=0.
- Requester inputs are sampled only in the grant cycle.

Optional Feature:
TRIG_SCHED_UNDEF_FLAG_EN
- Defined: adds output resp_undef (1 bit, valid with resp_valid). It is 1 when the result is mathematically undefined:
  - tan or sec with ref=90
  - cot or cosec with ref=0
  - invalid func code
- When resp_undef is set, resp_data is forced to 64'h7FF8_0000_0000_0000 (qNaN).
- Undefined: the port is absent and LUT data is passed through unchanged.

Decomposition:
- Shared package/defines: function-code constants (FUNC_SIN..FUNC_COSEC), FSM state encoding, and the DEG_90/180/270/360 constants; `DATA_WIDTH comes from the existing defines.
- Sub-module rr_arbiter: parameterized by NUM_REQ. Inputs: req vector, enable, rr_ptr. Outputs: one-hot grant and encoded ID.

Test Plan:
- Req0 sin 30° -> lut_en=6'b000001, quadrant=0, lut_angle=30. resp_valid 4 cycles after accept, resp_id=0, resp_data = LUT value.
- Req1 cot 100° -> quadrant=1, lut_angle=80, lut_en=6'b001000.
- Req2 cos 745° -> 2 REDUCE subtractions, quadrant=0, lut_angle=25, resp_valid 6 cycles after accept.
- All 4 requesters valid at once -> grant order 0,1,2,3. With 2 and 3 re-requesting, the next grants are 2 then 3 (rr_ptr wrap). No grant occurs during RESP.
- resp_ready held low for 5 cycles -> resp_valid, resp_data and resp_id stable. reset_n low during REDUCE -> all outputs return to reset values and no response is produced.
- With TRIG_SCHED_UNDEF_FLAG_EN: tan 270° -> resp_undef=1, resp_data=64'h7FF8000000000000. Func code 7 -> resp_undef=1.

Source files
------------

// File: rtl/trig_lut_scheduler_pkg.sv
// Shared function codes, angle constants and FSM encoding for trig_lut_scheduler.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package trig_lut_scheduler_pkg;

  localparam logic [2:0] FUNC_SIN   = 3'd0;
  localparam logic [2:0] FUNC_COS   = 3'd1;
  localparam logic [2:0] FUNC_TAN   = 3'd2;
  localparam logic [2:0] FUNC_COT   = 3'd3;
  localparam logic [2:0] FUNC_SEC   = 3'd4;
  localparam logic [2:0] FUNC_COSEC = 3'd5;

  localparam int unsigned DEG_90  = 90;
  localparam int unsigned DEG_180 = 180;
  localparam int unsigned DEG_270 = 270;
  localparam int unsigned DEG_360 = 360;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    QUAD,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  function automatic logic func_valid(input logic [2:0] f);
    return f <= FUNC_COSEC;
  endfunction

endpackage

// File: rtl/trig_lut_scheduler_if.sv
// Requester/consumer bus of trig_lut_scheduler; TRIG_SCHED_UNDEF_FLAG_EN adds resp_undef.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface trig_lut_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*3-1:0]       req_func;
  logic [NUM_REQ*ANGLE_W-1:0] req_angle;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [`DATA_WIDTH*2-1:0]   resp_data;
  logic [ID_W-1:0]            resp_id;
`ifdef TRIG_SCHED_UNDEF_FLAG_EN
  logic                       resp_undef;

  modport master (output req_valid, req_func, req_angle, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_id, resp_undef);
  modport slave  (input  req_valid, req_func, req_angle, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_id, resp_undef);
`else
  modport master (output req_valid, req_func, req_angle, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_id);
  modport slave  (input  req_valid, req_func, req_angle, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_id);
`endif
endinterface

// File: rtl/trig_lut_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);
  logic [NUM_REQ-1:0] req_rot;
  logic               found;
  int unsigned        sel;

  // Rotate so that bit 0 is the requester at rr_ptr; the first set bit wins.
  assign req_rot = NUM_REQ'({req, req} >> rr_ptr);

  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sel   = 32'(rr_ptr) + i;
      end
    end
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    id    = ID_W'(sel);
    grant = (enable && found) ? (NUM_REQ'(1) << id) : '0;
  end
endmodule

// File: rtl/trig_lut_scheduler.sv
// Round-robin scheduler sharing one trig LUT bank; angle reduction, quadrant mapping, result return.
// Optional: TRIG_SCHED_UNDEF_FLAG_EN adds resp_undef and forces qNaN for undefined results.
module trig_lut_scheduler
  import trig_lut_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  trig_lut_scheduler_if.slave      bus,
  output logic [5:0]               lut_en,
  output logic [1:0]               lut_quadrant,
  output logic [`DATA_WIDTH-1:0]   lut_angle,
  input  logic [`DATA_WIDTH*2-1:0] lut_result,
  output logic                     busy
);
  state_t             state;
  logic [ID_W-1:0]    rr_ptr, gnt_id, id_r;
  logic [NUM_REQ-1:0] gnt;
  logic               arb_en;
  logic [2:0]         func_r, func_c;
  logic [ANGLE_W-1:0] angle_r, angle_c;
  logic [8:0]         a9, ref_c;
  logic [1:0]         quad_c;

  // Accept strobe is combinational so valid&ready coincide on the sampling edge.
  assign arb_en = (state == IDLE) && reset_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .enable (arb_en),
    .rr_ptr (rr_ptr),
    .grant  (gnt),
    .id     (gnt_id)
  );

  assign bus.req_ready = gnt;
  assign busy          = (state != IDLE);

  always_comb begin
    func_c  = '0;
    angle_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        func_c  = bus.req_func[i*3 +: 3];
        angle_c = bus.req_angle[i*ANGLE_W +: ANGLE_W];
      end
    end
  end

  // After REDUCE the angle is below 360, so nine bits carry it.
  assign a9 = angle_r[8:0];

  always_comb begin
    if (a9 < 9'(DEG_90)) begin
      quad_c = 2'd0;
      ref_c  = a9;
    end else if (a9 < 9'(DEG_180)) begin
      quad_c = 2'd1;
      ref_c  = 9'(DEG_180) - a9;
    end else if (a9 < 9'(DEG_270)) begin
      quad_c = 2'd2;
      ref_c  = a9 - 9'(DEG_180);
    end else begin
      quad_c = 2'd3;
      ref_c  = 9'(DEG_360) - a9;
    end
  end

`ifdef TRIG_SCHED_UNDEF_FLAG_EN
  logic undef_c;
  always_comb begin
    case (func_r)
      FUNC_SIN, FUNC_COS:   undef_c = 1'b0;
      FUNC_TAN, FUNC_SEC:   undef_c = (lut_angle == `DATA_WIDTH'(DEG_90));
      FUNC_COT, FUNC_COSEC: undef_c = (lut_angle == '0);
      default:              undef_c = 1'b1;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      id_r           <= '0;
      func_r         <= '0;
      angle_r        <= '0;
      lut_en         <= '0;
      lut_quadrant   <= '0;
      lut_angle      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
`ifdef TRIG_SCHED_UNDEF_FLAG_EN
      bus.resp_undef <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          func_r  <= func_c;
          angle_r <= angle_c;
          id_r    <= gnt_id;
          rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state   <= REDUCE;
        end
        REDUCE: begin
          if (angle_r >= ANGLE_W'(DEG_360)) angle_r <= angle_r - ANGLE_W'(DEG_360);
          else                              state   <= QUAD;
        end
        QUAD: begin
          lut_quadrant <= quad_c;
          lut_angle    <= `DATA_WIDTH'(ref_c);
          if (func_valid(func_r)) begin
            // Enable rises with quadrant/angle so the registered LUTs see them in ISSUE.
            lut_en <= 6'b1 << func_r;
            state  <= ISSUE;
          end else begin
            bus.resp_id    <= id_r;
            bus.resp_valid <= 1'b1;
`ifdef TRIG_SCHED_UNDEF_FLAG_EN
            bus.resp_data  <= QNAN;
            bus.resp_undef <= 1'b1;
`else
            bus.resp_data  <= '0;
`endif
            state <= RESP;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          lut_en         <= '0;
          bus.resp_id    <= id_r;
          bus.resp_valid <= 1'b1;
`ifdef TRIG_SCHED_UNDEF_FLAG_EN
          bus.resp_undef <= undef_c;
          bus.resp_data  <= undef_c ? QNAN : lut_result;
`else
          bus.resp_data  <= lut_result;
`endif
          state <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Scoreboard bench for trig_lut_scheduler with a registered stand-in LUT bank.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_trig_lut_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ANGLE_W = 16;
  localparam int unsigned ID_W    = 2;
  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [5:0]               lut_en;
  logic [1:0]               lut_quadrant;
  logic [`DATA_WIDTH-1:0]   lut_angle;
  logic [`DATA_WIDTH*2-1:0] lut_result = '0;
  logic                     busy;

  trig_lut_scheduler_if #(.NUM_REQ(NUM_REQ), .ANGLE_W(ANGLE_W), .ID_W(ID_W)) bus ();

  trig_lut_scheduler #(.NUM_REQ(NUM_REQ), .ANGLE_W(ANGLE_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .lut_en       (lut_en),
    .lut_quadrant (lut_quadrant),
    .lut_angle    (lut_angle),
    .lut_result   (lut_result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stand-in LUT word tags the enable, quadrant and angle the bank saw.
  function automatic logic [63:0] lut_word(input logic [5:0] en, input logic [1:0] q,
                                           input logic [31:0] a);
    return {16'hA5A5, 2'b00, en, 6'b000000, q, a};
  endfunction

  always @(posedge clk)
    lut_result <= (lut_en != '0) ? lut_word(lut_en, lut_quadrant, lut_angle) : '0;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    int unsigned     lat;
    logic            undef;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_resp(input logic [ID_W-1:0] id, input logic [63:0] data,
                             input int unsigned lat, input logic undef);
    exp_t e;
    e.id = id; e.data = data; e.lat = lat; e.undef = undef;
    sb.push_back(e);
  endtask

  task automatic set_req(input int unsigned i, input logic [2:0] f, input logic [15:0] a);
    bus.req_func[i*3 +: 3]            = f;
    bus.req_angle[i*ANGLE_W +: ANGLE_W] = a;
    bus.req_valid[i]                  = 1'b1;
  endtask

  // One clock; requesters drop valid once their accept strobe has been seen.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((sb.size() != 0 || busy || bus.req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", 64'((sb.size() == 0) && !busy && (bus.req_valid == '0)), 64'd1);
  endtask

  initial begin : monitor
    logic            prev_v;
    logic [63:0]     hold_data;
    logic [ID_W-1:0] hold_id;
    exp_t            e;
    prev_v = 1'b0;
    hold_data = '0;
    hold_id = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.req_ready != '0) acc_cyc = cyc + 1;
        if (bus.resp_valid && bus.req_valid != '0)
          check("no_grant_in_resp", 64'(bus.req_ready), 64'd0);
        if (bus.resp_valid && !prev_v) begin
          hold_data = bus.resp_data;
          hold_id   = bus.resp_id;
          if (sb.size() != 0 && sb[0].lat != 0)
            check("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
        end else if (bus.resp_valid) begin
          check("stable_data", bus.resp_data, hold_data);
          check("stable_id", 64'(bus.resp_id), 64'(hold_id));
        end
        if (bus.resp_valid && bus.resp_ready) begin
          if (sb.size() == 0) begin
            check("spurious_resp", 64'(bus.resp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("resp_id", 64'(bus.resp_id), 64'(e.id));
            check("resp_data", bus.resp_data, e.data);
`ifdef TRIG_SCHED_UNDEF_FLAG_EN
            check("resp_undef", 64'(bus.resp_undef), 64'(e.undef));
`endif
          end
        end
        prev_v = bus.resp_valid;
      end
    end
  end

  initial begin : stimulus
    int unsigned n;
    bus.req_valid  = '0;
    bus.req_func   = '0;
    bus.req_angle  = '0;
    bus.resp_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_lut_en", 64'(lut_en), 64'd0);
    check("rst_lut_quadrant", 64'(lut_quadrant), 64'd0);
    check("rst_lut_angle", 64'(lut_angle), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single requests: sin 30, cot 100, cos 745 (two subtractions), sec 200.
    set_req(0, 3'd0, 16'd30);  expect_resp(0, lut_word(6'b000001, 2'd0, 32'd30), 4, 1'b0);
    wait_idle(40);
    set_req(1, 3'd3, 16'd100); expect_resp(1, lut_word(6'b001000, 2'd1, 32'd80), 4, 1'b0);
    wait_idle(40);
    set_req(2, 3'd1, 16'd745); expect_resp(2, lut_word(6'b000010, 2'd0, 32'd25), 6, 1'b0);
    wait_idle(40);
    set_req(3, 3'd4, 16'd200); expect_resp(3, lut_word(6'b010000, 2'd2, 32'd20), 4, 1'b0);
    wait_idle(40);

    // All four at once with rr_ptr back at 0: grants 0,1,2,3.
    set_req(0, 3'd2, 16'd45);  expect_resp(0, lut_word(6'b000100, 2'd0, 32'd45), 4, 1'b0);
    set_req(1, 3'd5, 16'd300); expect_resp(1, lut_word(6'b100000, 2'd3, 32'd60), 4, 1'b0);
    set_req(2, 3'd0, 16'd180); expect_resp(2, lut_word(6'b000001, 2'd2, 32'd0),  4, 1'b0);
    set_req(3, 3'd1, 16'd90);  expect_resp(3, lut_word(6'b000010, 2'd1, 32'd90), 4, 1'b0);
    wait_idle(120);

    // Requesters 2 and 3 again after the pointer wrapped.
    set_req(2, 3'd0, 16'd270); expect_resp(2, lut_word(6'b000001, 2'd3, 32'd90), 4, 1'b0);
    set_req(3, 3'd2, 16'd360); expect_resp(3, lut_word(6'b000100, 2'd0, 32'd0),  5, 1'b0);
    wait_idle(80);

    // Consumer stalls for five cycles.
    bus.resp_ready = 1'b0;
    set_req(0, 3'd1, 16'd500); expect_resp(0, lut_word(6'b000010, 2'd1, 32'd40), 5, 1'b0);
    n = 0;
    while (!bus.resp_valid && n < 30) begin tick(); n++; end
    check("stall_valid_seen", 64'(bus.resp_valid), 64'd1);
    repeat (5) tick();
    bus.resp_ready = 1'b1;
    wait_idle(40);

    // Invalid function code.
    set_req(1, 3'd7, 16'd10);
`ifdef TRIG_SCHED_UNDEF_FLAG_EN
    expect_resp(1, QNAN, 0, 1'b1);
`else
    expect_resp(1, 64'd0, 0, 1'b0);
`endif
    wait_idle(40);

    // Reset while reducing 1000 degrees: no response may follow.
    set_req(2, 3'd0, 16'd1000);
    tick();
    check("busy_in_reduce", 64'(busy), 64'd1);
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("abort_lut_en", 64'(lut_en), 64'd0);
    check("abort_lut_angle", 64'(lut_angle), 64'd0);
    check("abort_resp_id", 64'(bus.resp_id), 64'd0);
    reset_n = 1'b1;
    repeat (12) tick();

    // rr_ptr reset to 0: requester 1 before 3.
    set_req(1, 3'd0, 16'd90); expect_resp(1, lut_word(6'b000001, 2'd1, 32'd90), 4, 1'b0);
    set_req(3, 3'd1, 16'd0);  expect_resp(3, lut_word(6'b000010, 2'd0, 32'd0),  4, 1'b0);
    wait_idle(80);

`ifdef TRIG_SCHED_UNDEF_FLAG_EN
    set_req(0, 3'd2, 16'd270); expect_resp(0, QNAN, 4, 1'b1);
    set_req(1, 3'd7, 16'd10);  expect_resp(1, QNAN, 0, 1'b1);
    wait_idle(80);
`endif

    repeat (10) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
